// File: rtl/psw_ctrl.sv
// psw_ctrl -- processor status word (PSW) controller.
//
// Holds the 16-bit PSW: C[0], Z[1], N[2], SLP[3], V[4], PRI[7:5], reserved[15:8].
// Flag-update requests from the ALU are applied one cycle after acceptance.
// An optional saved-PSW stack handles exception entry (push) and return (pop).
//
// Build option: define PSW_STACK_EN to compile in the exception stack. Without
// it, exc_push/exc_pop are ignored, upd_ready is tied to 1 and the stack
// status outputs are constants (empty, count 0, no error).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   upd_valid/ready     flag-update handshake (ready drops during push/pop)
//   upd_op              0 NOP, 1 ADD, 2 SUB, 3 LOGIC, 4 SHIFT, 5 SETCC, 6 CLRCC, 7 LOAD
//   upd_a/b/res         ALU operands and result, WIDTH bits
//   upd_we              write enable for ADD/SUB/LOGIC flag results
//   upd_cc              field select {V, SLP, N, Z, C} for SETCC/CLRCC
//   exc_push, exc_pri   exception entry with new priority
//   exc_pop             exception return (wins over a simultaneous push)
//   psw_q               registered PSW
//   stk_cnt/full/empty  stack occupancy; stk_err sticky over/underflow flag
module psw_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [2:0]                 upd_op,
  input  logic [WIDTH-1:0]           upd_a,
  input  logic [WIDTH-1:0]           upd_b,
  input  logic [WIDTH-1:0]           upd_res,
  input  logic                       upd_we,
  input  logic [4:0]                 upd_cc,
  input  logic                       exc_push,
  input  logic [2:0]                 exc_pri,
  input  logic                       exc_pop,
  output logic [15:0]                psw_q,
  output logic [$clog2(DEPTH+1)-1:0] stk_cnt,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       stk_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_LOGIC = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_SETCC = 3'd5;
  localparam logic [2:0] OP_CLRCC = 3'd6;
  localparam logic [2:0] OP_LOAD  = 3'd7;

  localparam logic [15:0] PSW_RST = 16'h00E0;  // PRI=7, all flags clear

  // ---------------------------------------------------------------------------
  // Flag computation from operand / result signs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_neg;
  logic             sgn_a, sgn_b, sgn_r;
  logic             flag_c, flag_v, flag_z;
  logic [15:0]      load_val;
  logic [15:0]      upd_psw;
  logic [15:0]      psw_d;

  // SUB is treated as an add of the negated second operand.
  assign b_neg = -upd_b;
  assign sgn_a = upd_a[WIDTH-1];
  assign sgn_r = upd_res[WIDTH-1];
  assign sgn_b = (upd_op == OP_SUB) ? b_neg[WIDTH-1] : upd_b[WIDTH-1];

  assign flag_c = (sgn_b & sgn_a) | ((sgn_b | sgn_a) & ~sgn_r);
  assign flag_v = (sgn_b == sgn_a) & (sgn_r != sgn_a);
  assign flag_z = (upd_res == '0);

  generate
    if (WIDTH >= 16) begin : g_load_trunc
      assign load_val = upd_a[15:0];
    end else begin : g_load_zext
      assign load_val = {{(16 - WIDTH){1'b0}}, upd_a};
    end
  endgenerate

  // PSW value produced by an accepted update request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned -- otherwise a latch is inferred.
    upd_psw = psw_q;
    case (upd_op)
      OP_ADD, OP_SUB, OP_LOGIC: begin
        if (upd_we) begin
          upd_psw[0] = flag_c;
          upd_psw[1] = flag_z;
          upd_psw[2] = sgn_r;
          upd_psw[4] = flag_v;
        end
      end
      OP_SHIFT: upd_psw[0]   = upd_a[0];
      OP_SETCC: upd_psw[4:0] = psw_q[4:0] | upd_cc;
      OP_CLRCC: upd_psw[4:0] = psw_q[4:0] & ~upd_cc;
      OP_LOAD:  upd_psw      = load_val;
      OP_NOP:   upd_psw      = psw_q;
      default:  upd_psw      = psw_q;
    endcase
  end

`ifdef PSW_STACK_EN
  // ---------------------------------------------------------------------------
  // Saved-PSW stack
  // ---------------------------------------------------------------------------
  logic [15:0]      stk_q [DEPTH];
  logic [15:0]      stk_top;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             do_push;

  // Push/pop own the cycle; any update request is stalled.
  assign upd_ready = ~(exc_push | exc_pop);
  assign stk_cnt   = cnt_q;
  assign stk_err   = err_q;
  assign stk_full  = (cnt_q == CNT_W'(DEPTH));
  assign stk_empty = (cnt_q == '0);

  // Entry just below the count is the most recently saved PSW.
  always_comb begin
    stk_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) stk_top = stk_q[i];
    end
  end

  always_comb begin
    psw_d   = psw_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    do_push = 1'b0;
    if (exc_pop) begin
      if (stk_empty) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        psw_d = stk_top;
      end
    end else if (exc_push) begin
      if (stk_full) begin
        err_d = 1'b1;
      end else begin
        do_push = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Exception entry clears all flags; reserved bits are carried over.
        psw_d   = {psw_q[15:8], exc_pri, 5'b00000};
      end
    end else if (upd_valid) begin
      psw_d = upd_psw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      psw_q <= PSW_RST;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      psw_q <= psw_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the stack is small and must read as zero after reset, so it is
    // built from resettable flops rather than left to an uninitialised RAM.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q == CNT_W'(i)) stk_q[i] <= psw_q;
      end
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Stack compiled out: exception inputs are ignored.
  // ---------------------------------------------------------------------------
  logic unused_exc;

  assign unused_exc = ^{exc_push, exc_pop, exc_pri};
  assign upd_ready  = 1'b1;
  assign stk_cnt    = '0;
  assign stk_full   = 1'b0;
  assign stk_empty  = 1'b1;
  assign stk_err    = 1'b0;
  assign psw_d      = upd_valid ? upd_psw : psw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psw_q <= PSW_RST;
    else        psw_q <= psw_d;
  end
`endif

endmodule

// File: doc/psw_ctrl.md
PSW_CTRL -- requirements
Module: psw_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width (legal 8..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the saved-PSW stack depth (legal 1..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port upd_valid, input, 1, meaning a flag-update request is present.
REQ-006 The block SHALL have port upd_ready, output, 1, meaning a request is accepted this cycle.
REQ-007 The block SHALL have port upd_op, input, 3, encoded: 0 NOP, 1 ADD, 2 SUB, 3 LOGIC, 4 SHIFT, 5 SETCC, 6 CLRCC, 7 LOAD.
REQ-008 The block SHALL have ports upd_a, upd_b and upd_res, input, WIDTH each, carrying the ALU operands and result.
REQ-009 The block SHALL have port upd_we, input, 1, gating flag writes for ADD, SUB and LOGIC.
REQ-010 The block SHALL have port upd_cc, input, 5, selecting the V, SLP, N, Z, C fields (bits 4..0) for SETCC/CLRCC.
REQ-011 The block SHALL have ports exc_push, input, 1, and exc_pri, input, 3, meaning exception entry with a new priority.
REQ-012 The block SHALL have port exc_pop, input, 1, meaning exception return.
REQ-013 The block SHALL have port psw_q, output, 16, the registered PSW: C[0], Z[1], N[2], SLP[3], V[4], PRI[7:5], reserved[15:8].
REQ-014 The block SHALL have ports stk_cnt (output, clog2(DEPTH+1)), stk_full (output, 1), stk_empty (output, 1) and stk_err (output, 1).

Function
REQ-015 An update SHALL be accepted when upd_valid and upd_ready are both 1, and SHALL appear on psw_q on the following edge (1-cycle latency).
REQ-016 upd_ready SHALL be the inverse of (exc_push or exc_pop); push or pop takes priority and the update is stalled.
REQ-017 For ADD and LOGIC, with s = sign(upd_b), a = sign(upd_a), r = sign(upd_res): C SHALL be (s&a)|((s|a)&~r), V SHALL be (s==a)&(r!=a), Z SHALL be (upd_res==0) and N SHALL be r.
REQ-018 SUB SHALL use the same equations with s taken as the sign of the two's complement (~upd_b+1) truncated to WIDTH.
REQ-019 ADD, SUB and LOGIC SHALL write C, Z, N and V only when upd_we=1; otherwise the PSW is unchanged.
REQ-020 SHIFT SHALL write C=upd_a[0] and leave all other bits unchanged, regardless of upd_we.
REQ-021 SETCC SHALL set each field selected by upd_cc; CLRCC SHALL clear each selected field; unselected fields SHALL be unchanged.
REQ-022 LOAD SHALL write psw_q = upd_a[15:0], zero-extended when WIDTH<16.
REQ-023 NOP SHALL leave the PSW unchanged.
REQ-024 A push SHALL, in one cycle, store psw_q at stack[stk_cnt], increment stk_cnt, and load the PSW with C, Z, N, V and SLP = 0 and PRI = exc_pri.
REQ-025 A pop SHALL, in one cycle, decrement stk_cnt and restore the PSW from the top entry.
REQ-026 When exc_push and exc_pop are both 1, pop SHALL win and push SHALL be ignored.
REQ-027 A push when stk_full SHALL leave the stack and PSW unchanged and set stk_err.
REQ-028 A pop when stk_empty SHALL leave the stack and PSW unchanged and set stk_err.
REQ-029 stk_err SHALL be sticky and cleared only by reset.
REQ-030 stk_full SHALL be (stk_cnt==DEPTH) and stk_empty SHALL be (stk_cnt==0); both SHALL be combinational from the count.

Reset
REQ-031 While rst_n=0, the block SHALL hold psw_q=16'h00E0 (PRI=7, all flags 0), stk_cnt=0, stk_err=0 and stack contents = 0.
REQ-032 Reset asserted mid-push or mid-pop SHALL abort the operation; no partial state SHALL persist.
REQ-033 After reset release, the first edge SHALL accept requests normally.

Configuration
REQ-034 With macro PSW_STACK_EN defined, the stack behaviour of REQ-024 to REQ-030 SHALL be compiled in.
REQ-035 Without PSW_STACK_EN, exc_push and exc_pop SHALL be ignored, upd_ready SHALL be constant 1, stk_cnt SHALL be 0, stk_empty SHALL be 1, stk_full SHALL be 0, stk_err SHALL be 0, and no stack storage SHALL be inferred.

Verification
REQ-036 WIDTH=16, SUB, a=16'h0005, b=16'h0005, res=0, we=1 -> next cycle C=1, Z=1, N=0, V=0.
REQ-037 ADD, a=16'h7FFF, b=16'h0001, res=16'h8000, we=1 -> V=1, N=1, C=0, Z=0; same request with we=0 -> PSW unchanged.
REQ-038 SETCC with upd_cc=5'b10001, then CLRCC with upd_cc=5'b00001 -> psw_q[4:0] goes 10001 then 10000; PRI unchanged.
REQ-039 DEPTH=2: push pri=3, push pri=5, push pri=6 -> stk_cnt=2, stk_full=1, stk_err=1, PRI=5; pop, pop -> PSW equals the pre-first-push value; a further pop leaves stk_err=1.
REQ-040 exc_push and upd_valid (LOAD 16'h001F) both asserted -> upd_ready=0, push occurs, LOAD is accepted on the following cycle.
REQ-041 Assert rst_n=0 asynchronously between edges during a push -> psw_q=16'h00E0 and stk_cnt=0 immediately, without waiting for a clock edge.
